cam_pixel_capture: RTL

- Writer-side counterpart of the HDMI output path: captures the OV7670-style parallel camera bus and writes RGB565 pixels into the write port of asyn_fifo, which the display side drains.
- Runs entirely in the camera pixel-clock domain. clk is driven by the camera PCLK.
- Responsibilities: frame synchronisation, start-up frame skipping, byte pairing, clipping, FIFO-full drop handling and error flagging.

---
 rtl/cam_pixel_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_capture.sv
// Camera-side writer: locks to the OV7670-style sync signals, drops the start-up frames,
// pairs bytes into RGB565 pixels and pushes them into the write port of the display FIFO.
module cam_pixel_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err,
  output logic        frame_err
);

  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 2);
  localparam int SW = $clog2(SKIP_FRAMES + 2);
  localparam logic [PW-1:0] PIX_MAX  = PW'(H_PIXELS);
  localparam logic [LW-1:0] LINE_MAX = LW'(V_LINES);
  localparam logic [LW-1:0] LINE_SAT = LW'(V_LINES + 1);
  localparam logic [SW-1:0] SKIP_MAX = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_SYNC       = 2'd0,
    S_SKIP       = 2'd1,
    S_WAIT_START = 2'd2,
    S_CAPTURE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_skip_cnt;
  logic [PW-1:0]   r_pix_cnt;
  logic [LW-1:0]   r_line_cnt;
  logic            r_byte_sel;
  logic [7:0]      r_byte_hi;
  logic            r_extra;
  logic            r_vs_q;
  logic            r_hr_q;
  logic            r_wr_en;
  logic [15:0]     r_dout;
  logic            r_frame_done;
  logic            r_overflow;
  logic            r_line_err;
  logic            r_frame_err;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_hr_fall;
  logic w_line_active;
  logic w_pix_room;

  assign w_vs_rise     = cam_vsync & ~r_vs_q;
  assign w_vs_fall     = ~cam_vsync & r_vs_q;
  assign w_hr_fall     = ~cam_href & r_hr_q;
  assign w_line_active = (r_line_cnt < LINE_MAX);
  assign w_pix_room    = (r_pix_cnt < PIX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC:       if (w_vs_rise) w_state_next = S_SKIP;
      S_SKIP:       if (w_vs_rise && (r_skip_cnt == SKIP_MAX)) w_state_next = S_WAIT_START;
      S_WAIT_START: if (w_vs_fall) w_state_next = S_CAPTURE;
      S_CAPTURE:    if (w_vs_rise) w_state_next = S_WAIT_START;
      default:      w_state_next = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_byte_sel   <= 1'b0;
      r_byte_hi    <= '0;
      r_extra      <= 1'b0;
      r_vs_q       <= 1'b0;
      r_hr_q       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_dout       <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_vs_q       <= cam_vsync;
      r_hr_q       <= cam_href;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;

      // Clear first so that any set below, being the later assignment, takes priority.
      if (err_clr) begin
        r_overflow  <= 1'b0;
        r_line_err  <= 1'b0;
        r_frame_err <= 1'b0;
      end

      if (r_state == S_SYNC && w_vs_rise) begin
        r_skip_cnt <= '0;
      end

      if (r_state == S_SKIP && w_vs_rise && (r_skip_cnt != SKIP_MAX)) begin
        r_skip_cnt <= r_skip_cnt + 1'b1;
      end

      if (r_state == S_WAIT_START && w_vs_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_byte_sel <= 1'b0;
        r_extra    <= 1'b0;
      end

      if (r_state == S_CAPTURE) begin
        // End of frame takes precedence; a line still open here is judged by the line count only.
        if (w_vs_rise) begin
          r_frame_done <= 1'b1;
          if (r_line_cnt != LINE_MAX) r_frame_err <= 1'b1;
        end else if (cam_href && w_line_active) begin
          if (!w_pix_room) begin
            r_extra <= 1'b1;
          end else if (!r_byte_sel) begin
            r_byte_hi  <= cam_data;
            r_byte_sel <= 1'b1;
          end else begin
            r_byte_sel <= 1'b0;
            r_dout     <= {r_byte_hi, cam_data};
            r_wr_en    <= ~full_fifo;
            if (full_fifo) r_overflow <= 1'b1;
            r_pix_cnt  <= r_pix_cnt + 1'b1;
          end
        end else if (w_hr_fall) begin
          if (w_line_active && ((r_pix_cnt != PIX_MAX) || r_byte_sel || r_extra)) begin
            r_line_err <= 1'b1;
          end
          r_pix_cnt  <= '0;
          r_byte_sel <= 1'b0;
          r_extra    <= 1'b0;
          if (r_line_cnt != LINE_SAT) r_line_cnt <= r_line_cnt + 1'b1;
        end
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;

endmodule
